// File: rtl/crc32_stream_if.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_stream_if
//  Description : Beat stream into the CRC-32 engine and its result outputs.
//                master = frame source (drives in_*), slave = crc32_stream.
//  Ports       : in_vld / in_sof / in_eof  beat qualifier and framing
//                in_keep[DATA_BYTES]       valid-byte mask (eof beat only)
//                in_data[8*DATA_BYTES]     frame bytes, lane 0 first on wire
//                out_vld / out_crc / out_ok / out_err  result and status
//  Revision    : 1.0  initial release
// ============================================================================
interface crc32_stream_if #(
    parameter int DATA_BYTES = 4
);
    logic                    in_vld;
    logic                    in_sof;
    logic                    in_eof;
    logic [DATA_BYTES-1:0]   in_keep;
    logic [8*DATA_BYTES-1:0] in_data;
    logic                    out_vld;
    logic [31:0]             out_crc;
    logic                    out_ok;
    logic                    out_err;

    modport master (
        output in_vld, in_sof, in_eof, in_keep, in_data,
        input  out_vld, out_crc, out_ok, out_err
    );

    modport slave (
        input  in_vld, in_sof, in_eof, in_keep, in_data,
        output out_vld, out_crc, out_ok, out_err
    );
endinterface
`default_nettype wire

// File: rtl/crc32_stream.sv
`default_nettype none
// ============================================================================
//  Module      : crc32_stream
//  Description : Ethernet CRC-32 (reflected 0x04C11DB7, init/xorout
//                0xFFFFFFFF) over a framed byte stream, DATA_BYTES bytes per
//                beat. The finished FCS appears one cycle after the eof beat.
//  Ports       : clk      system clock
//                rst_n    asynchronous active-low reset
//                strm     crc32_stream_if.slave (beat inputs, result outputs)
//  Parameters  : DATA_BYTES  bytes per beat, legal values 1, 2, 4, 8
//  Options     : CRC32_CHECK_EN  when defined, out_ok flags a frame whose
//                trailing FCS leaves the good residue 0xDEBB20E3; when
//                undefined out_ok is tied low and no comparator is built.
//  Revision    : 1.0  initial release
// ============================================================================
module crc32_stream #(
    parameter int DATA_BYTES = 4
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    crc32_stream_if.slave   strm
);

    localparam logic [31:0] C_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] C_SEED      = 32'hFFFFFFFF;
`ifdef CRC32_CHECK_EN
    localparam logic [31:0] C_RESIDUE   = 32'hDEBB20E3;
`endif

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    state_t                r_state;
    logic [31:0]           r_crc;
    logic                  r_vld;
    logic [31:0]           r_crc_out;
    logic                  r_err;
`ifdef CRC32_CHECK_EN
    logic                  r_ok;
`endif

    logic [DATA_BYTES-1:0] w_lane_en;
    logic [31:0]           w_crc_start;
    logic [31:0]           w_crc_next;

    // Bit-serial form of tab[(crc^b)&8'hFF] ^ (crc>>8); both give the same
    // result and this one lets synthesis flatten the XOR tree per lane.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc,
                                             input logic [7:0]  b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            c = c[0] ? ((c >> 1) ^ C_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // On the eof beat only the contiguous run of keep bits starting at
    // lane 0 counts; once a 0 is seen every higher lane is disabled.
    always_comb begin
        logic run;
        run       = 1'b1;
        w_lane_en = '0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            run          = run & (~strm.in_eof | strm.in_keep[i]);
            w_lane_en[i] = run;
        end
    end

    // sof always restarts from the seed, which also covers the abort case.
    assign w_crc_start = strm.in_sof ? C_SEED : r_crc;

    always_comb begin
        logic [31:0] c;
        c = w_crc_start;
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (w_lane_en[i]) begin
                c = crc_byte(c, strm.in_data[8*i +: 8]);
            end
        end
        w_crc_next = c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_crc     <= C_SEED;
            r_vld     <= 1'b0;
            r_crc_out <= 32'h0;
            r_err     <= 1'b0;
`ifdef CRC32_CHECK_EN
            r_ok      <= 1'b0;
`endif
        end else begin
            r_vld <= 1'b0;
            r_err <= 1'b0;
            if (strm.in_vld) begin
                if (strm.in_sof || (r_state == ST_FRAME)) begin
                    // A sof arriving mid-frame abandons the open frame.
                    if (strm.in_sof && (r_state == ST_FRAME)) begin
                        r_err <= 1'b1;
                    end
                    if (strm.in_eof) begin
                        r_vld     <= 1'b1;
                        r_crc_out <= bswap32(~w_crc_next);
`ifdef CRC32_CHECK_EN
                        r_ok      <= (w_crc_next == C_RESIDUE);
`endif
                        r_state   <= ST_IDLE;
                        r_crc     <= C_SEED;
                    end else begin
                        r_state   <= ST_FRAME;
                        r_crc     <= w_crc_next;
                    end
                end else begin
                    // Beat outside any frame: dropped and flagged.
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign strm.out_vld = r_vld;
    assign strm.out_crc = r_crc_out;
    assign strm.out_err = r_err;
`ifdef CRC32_CHECK_EN
    assign strm.out_ok  = r_ok;
`else
    assign strm.out_ok  = 1'b0;
`endif

endmodule
`default_nettype wire
